// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall-bit indices,
// canonical stall vectors, FSM state encoding and bus widths.
package pipe_ctrl_pkg;

  localparam int REG_BUS_W   = 32;
  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;

  localparam int IDX_PC    = 0;
  localparam int IDX_IF_ID = 1;
  localparam int IDX_ID    = 2;
  localparam int IDX_EX    = 3;
  localparam int IDX_MEM   = 4;
  localparam int IDX_WB    = 5;

  typedef logic [STALL_W-1:0] stall_t;

  localparam stall_t NONE     = 6'b000000;
  // Holding a stage also holds everything upstream of it.
  localparam stall_t STALL_ID = 6'b000111;
  localparam stall_t STALL_EX = 6'b001111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Loadable down-counter for the divide sequence; saturates at zero and reports
// when it gets there.
module pipe_ctrl_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use and divide stalls into a
// per-stage hold vector and turns a MEM exception into a one-cycle flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id,
  input  logic                   ex_div_start,
  input  logic                   excp_i,
  input  logic [INST_ADDR_W-1:0] excp_pc_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_o,
  output logic [INST_ADDR_W-1:0] new_pc_o,
  output logic                   div_busy_o,
  output logic                   div_done_o
);

  // The entry cycle is already a held cycle and the final DIV cycle releases EX.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_e                 state_q;
  state_e                 state_d;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_ADDR_W-1:0] pc_d;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;

  pipe_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (DIV_LOAD),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      RUN: begin
        if (excp_i) begin
          state_d = FLUSH;
          pc_d    = excp_pc_i;
        end else if (ex_div_start) begin
          state_d  = DIV;
          cnt_load = 1'b1;
        end
      end
      DIV: begin
        if (excp_i) begin
          state_d = FLUSH;
          pc_d    = excp_pc_i;
        end else if (cnt_zero) begin
          state_d = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // flush/busy/done decode only registered state, so an exception arriving in
  // the final DIV cycle cannot retract a div_done_o already presented.
  always_comb begin
    stall_o    = NONE;
    flush_o    = 1'b0;
    div_busy_o = 1'b0;
    div_done_o = 1'b0;
    case (state_q)
      RUN: begin
        if (!excp_i) begin
          if (ex_div_start) begin
            stall_o = STALL_EX;
          end else if (stallreq_id) begin
            stall_o = STALL_ID;
          end
        end
      end
      DIV: begin
        div_busy_o = 1'b1;
        if (cnt_zero) begin
          div_done_o = 1'b1;
        end else if (!excp_i) begin
          stall_o = STALL_EX;
        end
      end
      FLUSH:   flush_o = 1'b1;
      default: stall_o = NONE;
    endcase
    // Requests are combinational, so mask them while reset is asserted.
    if (!rst) begin
      stall_o = NONE;
    end
  end

  assign new_pc_o = pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl: a cycle-level reference model
// pushes expected outputs, a monitor pops and compares them mid-cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_div_start = 1'b0;
  logic        excp_i = 1'b0;
  logic [31:0] excp_pc_i = '0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_busy_o;
  logic        div_done_o;

  pipe_ctrl #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_div_start (ex_div_start),
    .excp_i       (excp_i),
    .excp_pc_i    (excp_pc_i),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .new_pc_o     (new_pc_o),
    .div_busy_o   (div_busy_o),
    .div_done_o   (div_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        chk_pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: cycles elapsed since the divide started (0 = none),
  // pending flush flag and the redirect address.
  int          m_div_age = 0;
  bit          m_flush = 1'b0;
  logic [31:0] m_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic id, input logic st, input logic ex,
                      input logic [31:0] pc);
    exp_t e;
    @(negedge clk);
    rst          = r;
    stallreq_id  = id;
    ex_div_start = st;
    excp_i       = ex;
    excp_pc_i    = pc;
    e = '0;
    if (!r) begin
      m_div_age = 0;
      m_flush   = 1'b0;
      m_pc      = '0;
      e.chk_pc  = 1'b1;
    end else begin
      e.flush  = m_flush;
      e.pc     = m_pc;
      e.chk_pc = m_flush;
      e.busy   = (m_div_age != 0);
      e.done   = (m_div_age == DIV_CYCLES - 1);
      if (m_flush)             e.stall = NONE;
      else if (m_div_age != 0) e.stall = (e.done || ex) ? NONE : STALL_EX;
      else if (ex)             e.stall = NONE;
      else if (st)             e.stall = STALL_EX;
      else if (id)             e.stall = STALL_ID;
      else                     e.stall = NONE;

      if (m_flush) begin
        m_flush = 1'b0;
      end else if (ex) begin
        m_flush   = 1'b1;
        m_pc      = pc;
        m_div_age = 0;
      end else if (m_div_age != 0) begin
        m_div_age = e.done ? 0 : m_div_age + 1;
      end else if (st) begin
        m_div_age = 1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("stall_o", 32'(stall_o), 32'(e.stall));
        check("flush_o", 32'(flush_o), 32'(e.flush));
        check("div_busy_o", 32'(div_busy_o), 32'(e.busy));
        check("div_done_o", 32'(div_done_o), 32'(e.done));
        if (e.chk_pc) check("new_pc_o", new_pc_o, e.pc);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Load-use for two cycles.
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Divide together with a load-use request, back-to-back start on done, reissue.
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(DIV_CYCLES - 2);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(DIV_CYCLES + 1);

    // Exception beats a simultaneous divide start.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0180);
    idle(2);

    // Exception in DIV cycle 10.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(9);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380);
    idle(DIV_CYCLES + 2);

    // Asynchronous reset while the counter holds 15, then a clean divide.
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(15);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(DIV_CYCLES + 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 399) != 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 29) == 0),
           $urandom);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
